// File: rtl/tdm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tdm_pkg
// Brief    : Shared slot geometry and FSM state type for the TDM demultiplexer.
// Revision : 1.0
// ============================================================================
package tdm_pkg;

    localparam int NSLOT  = 8;
    localparam int SLOT_W = 3;

    typedef enum logic [0:0] {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/tdm_slot_ctr.sv
`default_nettype none
// ============================================================================
// Module   : tdm_slot_ctr
// Brief    : Slot index counter; load forces slot 1, inc advances with wrap.
// Revision : 1.0
// ============================================================================
module tdm_slot_ctr
    import tdm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load1,
    input  logic              inc,
    output logic [SLOT_W-1:0] slot
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot <= '0;
        end else if (load1) begin
            // Slot 0 was just captured alongside FS, so the next slot is 1.
            slot <= SLOT_W'(1);
        end else if (inc) begin
            if (slot == SLOT_W'(NSLOT - 1)) begin
                slot <= '0;
            end else begin
                slot <= slot + SLOT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/tdm_demux8.sv
`default_nettype none
// ============================================================================
// Module   : tdm_demux8
// Brief    : 8-slot serial TDM demultiplexer with frame-sync lock and resync.
// Revision : 1.0
// ============================================================================
module tdm_demux8
    import tdm_pkg::*;
#(
    parameter bit SYNC_CHECK = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              D,
    input  logic              V,
    input  logic              FS,
    output logic [NSLOT-1:0]  P,
    output logic              PV,
    output logic [SLOT_W-1:0] SLOT,
    output logic              LOCK,
    output logic              SERR
);

    state_t           r_state;
    logic [NSLOT-2:0] r_shadow;     // slots 0..6; slot 7 goes straight into P

    logic w_start;
    logic w_resync;
    logic w_load1;
    logic w_inc;
    logic w_last;

    assign w_start  = V & FS & (r_state == HUNT);
    assign w_resync = V & FS & (r_state == LOCKED) & (SYNC_CHECK != 1'b0)
                    & (SLOT != '0);
    assign w_load1  = w_start | w_resync;
    assign w_inc    = V & (r_state == LOCKED) & ~w_resync;
    assign w_last   = w_inc & (SLOT == SLOT_W'(NSLOT - 1));

    tdm_slot_ctr u_slot_ctr (
        .clk   (clk),
        .rst   (rst),
        .load1 (w_load1),
        .inc   (w_inc),
        .slot  (SLOT)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= HUNT;
            r_shadow <= '0;
            P        <= '0;
            PV       <= 1'b0;
            LOCK     <= 1'b0;
            SERR     <= 1'b0;
        end else begin
            PV   <= w_last;
            SERR <= w_resync;
            if (w_load1) begin
                // A resync drops the partial frame; only the new slot 0 survives.
                r_shadow <= {{(NSLOT-2){1'b0}}, D};
                r_state  <= LOCKED;
                LOCK     <= 1'b1;
            end else if (w_inc) begin
                if (w_last) begin
                    P <= {D, r_shadow};
                end else begin
                    r_shadow[SLOT] <= D;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux8.sv
`default_nettype none
// ============================================================================
// Module   : tb_tdm_demux8
// Brief    : Self-checking bench for tdm_demux8 (both SYNC_CHECK settings).
// Revision : 1.0
// ============================================================================
module tb_tdm_demux8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       D   = 1'b0;
    logic       V   = 1'b0;
    logic       FS  = 1'b0;

    logic [7:0] p0, p1;
    logic       pv0, pv1, lock0, lock1, serr0, serr1;
    logic [2:0] slot0, slot1;

    int total = 0;
    int bad   = 0;

    // Frame-level reference: index 0 models SYNC_CHECK=1, index 1 SYNC_CHECK=0.
    bit         m_lock [2];
    int         m_idx  [2];
    bit         m_bits [2][8];
    logic [7:0] m_p    [2];
    bit         m_pv   [2];
    bit         m_serr [2];
    bit         m_sc   [2] = '{1'b1, 1'b0};

    always #5 clk = ~clk;

    tdm_demux8 #(.SYNC_CHECK(1'b1)) u_sc1 (
        .clk(clk), .rst(rst), .D(D), .V(V), .FS(FS),
        .P(p0), .PV(pv0), .SLOT(slot0), .LOCK(lock0), .SERR(serr0)
    );

    tdm_demux8 #(.SYNC_CHECK(1'b0)) u_sc0 (
        .clk(clk), .rst(rst), .D(D), .V(V), .FS(FS),
        .P(p1), .PV(pv1), .SLOT(slot1), .LOCK(lock1), .SERR(serr1)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_lock[k] = 1'b0;
            m_idx[k]  = 0;
            m_p[k]    = 8'h00;
            m_pv[k]   = 1'b0;
            m_serr[k] = 1'b0;
            for (int i = 0; i < 8; i++) m_bits[k][i] = 1'b0;
        end
    endtask

    task automatic model_step(input bit d, input bit v, input bit fs);
        for (int k = 0; k < 2; k++) begin
            m_pv[k]   = 1'b0;
            m_serr[k] = 1'b0;
            if (v) begin
                if (!m_lock[k] || (m_sc[k] && fs && m_idx[k] != 0)) begin
                    if (!m_lock[k] && !fs) continue;
                    if (m_lock[k]) m_serr[k] = 1'b1;
                    m_lock[k] = 1'b1;
                    for (int i = 0; i < 8; i++) m_bits[k][i] = 1'b0;
                    m_bits[k][0] = d;
                    m_idx[k] = 1;
                end else begin
                    m_bits[k][m_idx[k]] = d;
                    if (m_idx[k] == 7) begin
                        for (int i = 0; i < 8; i++) m_p[k][i] = m_bits[k][i];
                        m_pv[k]  = 1'b1;
                        m_idx[k] = 0;
                    end else begin
                        m_idx[k]++;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        chk("P_sc1",    p0,            m_p[0]);
        chk("PV_sc1",   {7'd0, pv0},   {7'd0, m_pv[0]});
        chk("SLOT_sc1", {5'd0, slot0}, 8'(m_idx[0]));
        chk("LOCK_sc1", {7'd0, lock0}, {7'd0, m_lock[0]});
        chk("SERR_sc1", {7'd0, serr0}, {7'd0, m_serr[0]});
        chk("P_sc0",    p1,            m_p[1]);
        chk("PV_sc0",   {7'd0, pv1},   {7'd0, m_pv[1]});
        chk("SLOT_sc0", {5'd0, slot1}, 8'(m_idx[1]));
        chk("LOCK_sc0", {7'd0, lock1}, {7'd0, m_lock[1]});
        chk("SERR_sc0", {7'd0, serr1}, {7'd0, m_serr[1]});
    endtask

    task automatic cycle(input bit d, input bit v, input bit fs);
        D  = d;
        V  = v;
        FS = fs;
        @(posedge clk);
        model_step(d, v, fs);
        #1;
        check_all();
    endtask

    task automatic send_bits(input logic [7:0] val, input bit fs_first, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) cycle(val[i], 1'b1, fs_first && (i == lo));
    endtask

    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("rst_P",    p0,            8'h00);
        chk("rst_LOCK", {7'd0, lock0}, 8'h00);
        @(negedge clk) rst = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        @(negedge clk) rst = 1'b0;

        // Data without FS never locks
        repeat (10) cycle(1'($urandom), 1'b1, 1'b0);
        chk("nofs_LOCK", {7'd0, lock0}, 8'h00);

        // Basic frame
        send_bits(8'h4D, 1'b1, 0, 7);
        chk("f4D_P",  p0,          8'h4D);
        chk("f4D_PV", {7'd0, pv0}, 8'h01);
        cycle(1'b0, 1'b0, 1'b0);

        // Back-to-back frames, continuous V
        send_bits(8'hA5, 1'b1, 0, 7);
        chk("fA5_P", p0, 8'hA5);
        send_bits(8'h3C, 1'b1, 0, 7);
        chk("f3C_P", p1, 8'h3C);

        // V gap after four bits
        send_bits(8'h4D, 1'b1, 0, 3);
        repeat (3) cycle(1'($urandom), 1'b0, 1'($urandom));
        chk("gap_SLOT", {5'd0, slot0}, 8'd4);
        send_bits(8'h4D, 1'b0, 4, 7);
        chk("gap_P", p0, 8'h4D);

        // FS reasserted at slot 5
        send_bits(8'hFF, 1'b1, 0, 4);
        cycle(1'b1, 1'b1, 1'b1);
        chk("rs_SERR1", {7'd0, serr0}, 8'h01);
        chk("rs_SERR0", {7'd0, serr1}, 8'h00);
        chk("rs_SLOT1", {5'd0, slot0}, 8'd1);
        chk("rs_P1",    p0,            8'h4D);
        send_bits(8'hC3, 1'b0, 1, 7);
        chk("rs_Pnew1", p0, 8'hC3);
        chk("rs_Pnew0", p1, 8'h7F);

        // Reset mid-frame
        send_bits(8'h00, 1'b1, 0, 2);
        async_reset();
        repeat (5) cycle(1'($urandom), 1'b1, 1'b0);
        chk("post_rst_LOCK", {7'd0, lock0}, 8'h00);
        send_bits(8'h96, 1'b1, 0, 7);
        chk("relock_P1", p0, 8'h96);
        chk("relock_P0", p1, 8'h96);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            cycle(1'($urandom), ($urandom_range(3) != 0), ($urandom_range(9) == 0));
            if ($urandom_range(199) == 0) async_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
